// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Shares one FIFO write port among N producers.
// Each producer has a valid/ready stream. The arbiter grants one producer at
// a time for a burst of up to MAX_BURST transfers. After that burst, the
// priority start moves to the next producer. Every handoff passes through a
// single IDLE cycle, which acts as an arbitration bubble.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous, active-low reset
//   req_valid  : per-requester valid
//   req_data   : packed data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : per-requester ready; only the owner's bit can be set
//   fifo_full  : full flag from the FIFO write port
//   fifo_write : write strobe to the FIFO
//   fifo_din   : data to the FIFO; zero while idle
//   grant      : one-hot owner; zero while idle
//   grant_id   : binary owner index; zero while idle
module fifo_write_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [N*WIDTH-1:0]    req_data,
  output logic [N-1:0]          req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_write,
  output logic [WIDTH-1:0]      fifo_din,
  output logic [N-1:0]          grant,
  output logic [$clog2(N)-1:0]  grant_id
);

  localparam int IDW = $clog2(N);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state, w_stateNext;
  logic [IDW-1:0]   r_owner, w_ownerNext;
  logic [IDW-1:0]   r_ptr,   w_ptrNext;
  logic [BW-1:0]    r_bcnt,  w_bcntNext;

  logic [WIDTH-1:0] w_dataArr [N];
  logic             w_ownerValid;
  logic             w_xfer;
  logic             w_lastBeat;
  logic [IDW-1:0]   w_ownerWrap;
  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_cand;
  logic             w_found;
  int               w_idx;

  // Split the packed data bus into one slice per requester.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_dataArr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // A transfer happens only when the owner is valid and the FIFO has room.
  // The last beat is checked against MAX_BURST-1 so that bcnt never has to
  // hold the value MAX_BURST.
  assign w_ownerValid = req_valid[r_owner];
  assign w_xfer       = (r_state == GRANT) && w_ownerValid && !fifo_full;
  assign w_lastBeat   = (r_bcnt == BW'(MAX_BURST - 1));
  assign w_ownerWrap  = (r_owner == IDW'(N - 1)) ? '0 : r_owner + 1'b1;

  // Rotating search that starts at ptr. Wrap-around is done with explicit
  // modulo arithmetic, so N does not need to be a power of two.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      w_cand = IDW'(w_idx);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // State register. Reset returns to IDLE right away, and that alone forces
  // every output to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_owner <= w_ownerNext;
      r_ptr   <= w_ptrNext;
      r_bcnt  <= w_bcntNext;
    end
  end

  // Next-state logic. A release happens when the burst is exhausted or when
  // the owner drops valid. A full FIFO stalls the owner and keeps bcnt as is.
  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_ptrNext   = r_ptr;
    w_bcntNext  = r_bcnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNext = GRANT;
          w_ownerNext = w_pick;
          w_bcntNext  = '0;
        end
      end
      GRANT: begin
        if (!w_ownerValid || (w_xfer && w_lastBeat)) begin
          w_stateNext = IDLE;
          w_ptrNext   = w_ownerWrap;
          w_bcntNext  = '0;
        end else if (w_xfer) begin
          w_bcntNext  = r_bcnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Output logic. Only the current owner is ever acknowledged or forwarded.
  always_comb begin
    grant      = '0;
    grant_id   = '0;
    req_ready  = '0;
    fifo_din   = '0;
    fifo_write = 1'b0;
    if (r_state == GRANT) begin
      grant[r_owner]     = 1'b1;
      grant_id           = r_owner;
      req_ready[r_owner] = !fifo_full;
      fifo_din           = w_dataArr[r_owner];
      fifo_write         = w_xfer;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter (N=4, WIDTH=8, MAX_BURST=4).
// Each producer drives a data counter that advances on its own handshake.
// Before each scenario, the bench queues the FIFO writes it expects.
// A monitor then compares every observed write against the head of that
// queue.
module tb_fifo_write_arbiter;

  localparam int N         = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_full = 1'b0;
  logic             fifo_write;
  logic [WIDTH-1:0] fifo_din;
  logic [N-1:0]     grant;
  logic [1:0]       grant_id;

  logic [7:0]       srcData [N];
  logic [N-1:0]     hsPend = '0;
  exp_t             expQ [$];
  int               checks = 0;
  int               failures = 0;

  fifo_write_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_din   (fifo_din),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  // Each producer presents its current counter value as data.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_data[i*WIDTH +: WIDTH] = srcData[i];
    end
  end

  // Mid-cycle monitor: it records handshakes and checks each write against
  // the expected-write queue.
  always @(negedge clk) begin
    exp_t e;
    hsPend = req_valid & req_ready;
    if (fifo_write) begin
      checks++;
      assert (expQ.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%0h expected=none", fifo_din);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checks++;
        assert (fifo_din === e.data) else begin
          failures++;
          $error("FAIL write_data observed=%0h expected=%0h", fifo_din, e.data);
        end
        checks++;
        assert (grant_id === e.id) else begin
          failures++;
          $error("FAIL write_id observed=%0d expected=%0d", grant_id, e.id);
        end
      end
    end
  end

  // A producer advances to its next data word once the edge commits its
  // handshake.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (hsPend[i]) begin
        srcData[i] = srcData[i] + 8'd1;
      end
    end
    hsPend = '0;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid);
    req_valid = valid;
  endtask

  task automatic pushExp(input int id, input int data);
    exp_t e;
    e.id   = 2'(id);
    e.data = 8'(data);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] expGrant,
                             input logic [1:0] expId, input logic expWrite,
                             input logic [N-1:0] expReady);
    checks++;
    assert (grant === expGrant) else begin
      failures++;
      $error("FAIL %s.grant observed=%b expected=%b", tag, grant, expGrant);
    end
    checks++;
    assert (grant_id === expId) else begin
      failures++;
      $error("FAIL %s.grant_id observed=%0d expected=%0d", tag, grant_id, expId);
    end
    checks++;
    assert (fifo_write === expWrite) else begin
      failures++;
      $error("FAIL %s.fifo_write observed=%b expected=%b", tag, fifo_write, expWrite);
    end
    checks++;
    assert (req_ready === expReady) else begin
      failures++;
      $error("FAIL %s.req_ready observed=%b expected=%b", tag, req_ready, expReady);
    end
  endtask

  initial begin
    int ids [5];
    ids = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) srcData[i] = 8'h00;

    // Reset held low: requests must be ignored.
    applyStimulus(4'b1111);
    tick();
    checkOutput("rst_hold", 4'b0000, 2'd0, 1'b0, 4'b0000);
    applyStimulus(4'b0101);
    #1;
    checkOutput("rst_toggle", 4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    applyStimulus(4'b0000);
    rst = 1'b1;
    tick();
    checkOutput("idle_norq", 4'b0000, 2'd0, 1'b0, 4'b0000);
    checks++;
    assert (fifo_din === 8'h00) else begin
      failures++;
      $error("FAIL idle_din observed=%0h expected=0", fifo_din);
    end

    // Single requester 2: a bubble, then 4 writes, then a bubble, then writes
    // resume.
    srcData[2] = 8'h10;
    for (int k = 0; k < 5; k++) pushExp(2, 'h10 + k);
    applyStimulus(4'b0100);
    checkOutput("single_bubble", 4'b0000, 2'd0, 1'b0, 4'b0000);
    for (int b = 0; b < 4; b++) begin
      tick();
      checkOutput("single_burst", 4'b0100, 2'd2, 1'b1, 4'b0100);
    end
    tick();
    checkOutput("single_release", 4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    checkOutput("single_resume", 4'b0100, 2'd2, 1'b1, 4'b0100);
    tick();
    applyStimulus(4'b0000);
    #1;
    checkOutput("single_drop", 4'b0100, 2'd2, 1'b0, 4'b0100);
    tick();
    checkOutput("single_idle", 4'b0000, 2'd0, 1'b0, 4'b0000);

    // Round-robin from pointer 0 with all four requesters valid.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) srcData[i] = 8'(i * 'h20);
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 4; b++)
        pushExp(ids[g], ids[g] * 'h20 + ((g == 4) ? 4 : 0) + b);
    applyStimulus(4'b1111);
    for (int g = 0; g < 5; g++) begin
      checkOutput("rr_bubble", 4'b0000, 2'd0, 1'b0, 4'b0000);
      for (int b = 0; b < 4; b++) begin
        tick();
        checkOutput("rr_grant", 4'(1 << ids[g]), 2'(ids[g]), 1'b1, 4'(1 << ids[g]));
      end
      tick();
    end
    applyStimulus(4'b0000);
    #1;
    checkOutput("rr_done", 4'b0000, 2'd0, 1'b0, 4'b0000);

    // Back-pressure: two writes, then a 3-cycle stall, then two more writes.
    tick();
    srcData[0] = 8'h80;
    for (int k = 0; k < 4; k++) pushExp(0, 'h80 + k);
    applyStimulus(4'b0001);
    checkOutput("bp_bubble", 4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    checkOutput("bp_w1", 4'b0001, 2'd0, 1'b1, 4'b0001);
    tick();
    checkOutput("bp_w2", 4'b0001, 2'd0, 1'b1, 4'b0001);
    tick();
    fifo_full = 1'b1;
    #1;
    checkOutput("bp_stall", 4'b0001, 2'd0, 1'b0, 4'b0000);
    tick();
    checkOutput("bp_stall", 4'b0001, 2'd0, 1'b0, 4'b0000);
    tick();
    checkOutput("bp_stall", 4'b0001, 2'd0, 1'b0, 4'b0000);
    tick();
    fifo_full = 1'b0;
    #1;
    checkOutput("bp_w3", 4'b0001, 2'd0, 1'b1, 4'b0001);
    tick();
    checkOutput("bp_w4", 4'b0001, 2'd0, 1'b1, 4'b0001);
    tick();
    applyStimulus(4'b0000);
    #1;
    checkOutput("bp_release", 4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();

    // Early release: owner 1 drops after a single write; requester 3 goes next.
    srcData[1] = 8'hA0;
    srcData[3] = 8'hC0;
    pushExp(1, 'hA0);
    applyStimulus(4'b1010);
    checkOutput("early_bubble", 4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    checkOutput("early_w1", 4'b0010, 2'd1, 1'b1, 4'b0010);
    tick();
    applyStimulus(4'b1000);
    #1;
    checkOutput("early_drop", 4'b0010, 2'd1, 1'b0, 4'b0010);
    tick();
    checkOutput("early_release", 4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    checkOutput("early_next", 4'b1000, 2'd3, 1'b1, 4'b1000);

    // Asynchronous reset mid-burst: the pending write must disappear at once.
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_rst", 4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    checkOutput("rst_low", 4'b0000, 2'd0, 1'b0, 4'b0000);
    applyStimulus(4'b1100);
    rst = 1'b1;
    pushExp(2, srcData[2]);
    #1;
    checkOutput("post_rst_bubble", 4'b0000, 2'd0, 1'b0, 4'b0000);
    tick();
    checkOutput("post_rst_grant", 4'b0100, 2'd2, 1'b1, 4'b0100);
    tick();
    applyStimulus(4'b0000);
    #1;
    checkOutput("post_rst_drop", 4'b0100, 2'd2, 1'b0, 4'b0100);
    tick();
    tick();
    checkOutput("final_idle", 4'b0000, 2'd0, 1'b0, 4'b0000);

    checks++;
    assert (expQ.size() == 0) else begin
      failures++;
      $error("FAIL pending_writes observed=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares one FIFO write port among N producer actors in a multi-dataflow network.
- Each producer presents a valid/ready stream. The arbiter grants one owner at a time for a bounded burst, then rotates priority.
- Sits between the producers and the write side of fifo_mono. It forwards the owner's data and write strobe and honours the FIFO's full flag.

Parameters:
- N, 4, number of requesters (N >= 2; need not be a power of two)
- WIDTH, 8, data width; must match the downstream FIFO WIDTH
- MAX_BURST, 4, maximum transfers per grant before a forced release (>= 1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  N  per-requester data valid
- req_data  input  N*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  output  N  per-requester ready; at most one bit set
- fifo_full  input  1  full flag from the FIFO write port
- fifo_write  output  1  write strobe to the FIFO write port
- fifo_din  output  WIDTH  data to the FIFO write port
- grant  output  N  one-hot current owner; all zero when idle
- grant_id  output  $clog2(N)  binary index of the owner; 0 when idle

Behaviour:
- Internal state:
  - FSM {IDLE, GRANT}
  - owner, $clog2(N) bits
  - ptr (rotating priority start), $clog2(N) bits
  - bcnt (burst count), $clog2(MAX_BURST+1) bits
- Reset (rst low, asynchronous): state=IDLE, owner=0, ptr=0, bcnt=0. All outputs go low/zero immediately, without waiting for a clock edge.
- Reset mid-burst: fifo_write deasserts immediately and no write commits on the following edge. After rst deasserts, arbitration restarts at requester 0.
- IDLE:
  - Outputs all zero.
  - If any req_valid is high, select the first i with req_valid[i]=1, searching i = ptr, ptr+1, ..., wrapping from N-1 to 0.
  - Next edge: owner=i, bcnt=0, state=GRANT.
  - No requests: stay in IDLE.
  - The IDLE cycle is a one-cycle arbitration bubble, required on every handoff.
- GRANT outputs (combinational from registered state and inputs):
  - grant = one-hot(owner); grant_id = owner.
  - req_ready[owner] = !fifo_full; all other req_ready bits = 0.
  - fifo_din = req_data[owner]; fifo_din is zero in IDLE.
  - fifo_write = req_valid[owner] && !fifo_full. This is the transfer condition; data is written on the same edge, with zero added latency.
- GRANT transitions, evaluated at each edge:
  - Transfer and bcnt+1 == MAX_BURST: release.
  - req_valid[owner] low (no transfer): release.
  - Transfer and bcnt+1 < MAX_BURST: bcnt increments, stay in GRANT.
  - fifo_full high with owner valid: stall. No transfer, bcnt holds, grant holds indefinitely (no timeout).
  - Release: state=IDLE, ptr = owner+1, with owner=N-1 wrapping to 0; bcnt=0.
- Non-owner requests never preempt the owner. Requests may rise or fall on any cycle.
- Data from a non-owner is never written and never acknowledged.
- Invariants:
  - At most one grant bit and one req_ready bit high.
  - fifo_write implies !fifo_full.
  - Each transfer corresponds to exactly one req_valid && req_ready handshake.
- Throughput:
  - A single continuously valid requester achieves MAX_BURST writes per MAX_BURST+1 cycles.
  - With all requesters valid, service order is strictly 0, 1, ..., N-1, 0, ...

Test Plan:
- Reset/idle: hold rst low, toggle req_valid -> grant=0, grant_id=0, fifo_write=0, req_ready=0. Release rst with no requests -> outputs stay 0.
- Single requester burst: N=4, MAX_BURST=4, req_valid[2] held high with data 0x10, 0x11, ... -> IDLE bubble, then 4 consecutive writes 0x10..0x13 with grant=4'b0100, then 1 idle cycle, then writes resume at 0x14.
- Round-robin: all four valid continuously -> grant_id sequence 0, 1, 2, 3, 0, each holding for 4 writes, with 1 bubble cycle between grants. Check ptr wrap from 3 to 0.
- Back-pressure: fifo_full high for 3 cycles mid-burst after 2 writes -> fifo_write=0 and req_ready=0 during the stall, grant held. Then exactly 2 more writes before release; no data lost or duplicated.
- Early release: owner 1 drops req_valid after 1 write while requester 3 is valid -> release. Next grant goes to 3 after one IDLE cycle, not to 0 or 2 if they are invalid.
- Async reset mid-burst: assert rst between edges while fifo_write=1 -> fifo_write drops before the next edge and no write is counted. After release, first grant goes to the lowest valid index starting from 0.
